// File: rtl/rpn_stack_core_if.sv
// rpn_stack_core_if: operand/opcode inputs and stack/flag outputs of the RPN engine.
// master drives data_in/op; slave (the core) drives the display and status signals.
interface rpn_stack_core_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic [WIDTH-1:0]           data_in;
    logic [2:0]                 op;
    logic [WIDTH-1:0]           top;
    logic [WIDTH-1:0]           second;
    logic [$clog2(DEPTH+1)-1:0] depth;
    logic                       busy;
    logic                       carry;
    logic                       err_ovf;
    logic                       err_unf;

    modport master (
        output data_in, op,
        input  top, second, depth, busy, carry, err_ovf, err_unf
    );

    modport slave (
        input  data_in, op,
        output top, second, depth, busy, carry, err_ovf, err_unf
    );
endinterface

// File: rtl/rpn_stack_core.sv
// rpn_stack_core: WIDTH-bit, DEPTH-entry RPN operand stack with key pulses and ALU.
// Define RPN_MUL_EN to build the sequential shift-add multiplier for opcode 010.
module rpn_stack_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic            CLOCK_50,
    input  logic [3:0]      KEY,
    rpn_stack_core_if.slave bus
);
    localparam int DW = $clog2(DEPTH+1);

    typedef logic [WIDTH-1:0]            word_t;
    typedef logic [DEPTH-1:0][WIDTH-1:0] stack_t;

    logic rst_n;
    logic key3_unused;
    assign rst_n       = KEY[1];
    assign key3_unused = KEY[3];

    // [1:0] synchronise, [2] holds the previous level for edge detection
    logic [2:0] psh_sync, exe_sync;
    logic       psh_p, exe_p;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            psh_sync <= '1;
            exe_sync <= '1;
            psh_p    <= 1'b0;
            exe_p    <= 1'b0;
        end else begin
            psh_sync <= {psh_sync[1:0], KEY[0]};
            exe_sync <= {exe_sync[1:0], KEY[2]};
            psh_p    <= psh_sync[2] & ~psh_sync[1];
            exe_p    <= exe_sync[2] & ~exe_sync[1];
        end
    end

    stack_t        stk_q, stk_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          idle;
    logic          mul_done;
    word_t         mul_lo;
    logic          mul_hi_nz;

    logic          has1, has2, full;
    logic [WIDTH:0] sum, dif;
    stack_t        popped;

    assign has1   = (cnt_q != '0);
    assign has2   = (cnt_q >= DW'(2));
    assign full   = (cnt_q == DW'(DEPTH));
    assign sum    = {1'b0, stk_q[1]} + {1'b0, stk_q[0]};
    assign dif    = {1'b0, stk_q[1]} - {1'b0, stk_q[0]};
    assign popped = {word_t'(0), stk_q[DEPTH-1:1]};

`ifdef RPN_MUL_EN
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH-1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               state_q, state_d;
    logic                 mul_go;
    logic [2*WIDTH-1:0]   mc_q, prod_q, prod_nx;
    word_t                mp_q;
    logic [BW-1:0]        bit_q;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (mul_go) state_d = S_MUL;
            S_MUL:  if (bit_q == LAST) state_d = S_IDLE;
        endcase
    end

    assign prod_nx   = prod_q + (mp_q[0] ? mc_q : '0);
    assign idle      = (state_q == S_IDLE);
    assign mul_done  = (state_q == S_MUL) && (bit_q == LAST);
    assign mul_lo    = prod_nx[WIDTH-1:0];
    assign mul_hi_nz = |prod_nx[2*WIDTH-1:WIDTH];
    assign bus.busy  = (state_q == S_MUL);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            mc_q   <= '0;
            prod_q <= '0;
            mp_q   <= '0;
            bit_q  <= '0;
        end else if (mul_go) begin
            mc_q   <= {{WIDTH{1'b0}}, stk_q[1]};
            mp_q   <= stk_q[0];
            prod_q <= '0;
            bit_q  <= '0;
        end else if (state_q == S_MUL) begin
            mc_q   <= mc_q << 1;
            mp_q   <= mp_q >> 1;
            prod_q <= prod_nx;
            bit_q  <= bit_q + BW'(1);
        end
    end
`else
    assign idle      = 1'b1;
    assign mul_done  = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi_nz = 1'b0;
    assign bus.busy  = 1'b0;
`endif

    always_comb begin
        stk_d   = stk_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
`ifdef RPN_MUL_EN
        mul_go  = 1'b0;
`endif
        if (mul_done) begin
            stk_d    = popped;
            stk_d[0] = mul_lo;
            cnt_d    = cnt_q - DW'(1);
            carry_d  = mul_hi_nz;
        end else if (idle && psh_p) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                stk_d = {stk_q[DEPTH-2:0], bus.data_in};
                cnt_d = cnt_q + DW'(1);
            end
        end else if (idle && exe_p) begin
            unique case (bus.op)
                3'b000: begin
                    if (!has2) unf_d = 1'b1;
                    else begin
                        stk_d    = popped;
                        stk_d[0] = sum[WIDTH-1:0];
                        cnt_d    = cnt_q - DW'(1);
                        carry_d  = sum[WIDTH];
                    end
                end
                3'b001: begin
                    if (!has2) unf_d = 1'b1;
                    else begin
                        stk_d    = popped;
                        stk_d[0] = dif[WIDTH-1:0];
                        cnt_d    = cnt_q - DW'(1);
                        carry_d  = dif[WIDTH];
                    end
                end
                3'b010: begin
`ifdef RPN_MUL_EN
                    if (!has2) unf_d = 1'b1;
                    else       mul_go = 1'b1;
`endif
                end
                3'b011: begin
                    if (!has2) unf_d = 1'b1;
                    else begin
                        stk_d[0] = stk_q[1];
                        stk_d[1] = stk_q[0];
                    end
                end
                3'b100: begin
                    if (!has1)     unf_d = 1'b1;
                    else if (full) ovf_d = 1'b1;
                    else begin
                        stk_d = {stk_q[DEPTH-2:0], stk_q[0]};
                        cnt_d = cnt_q + DW'(1);
                    end
                end
                3'b101: begin
                    if (!has1) unf_d = 1'b1;
                    else begin
                        stk_d = popped;
                        cnt_d = cnt_q - DW'(1);
                    end
                end
                3'b110: begin
                    if (!has1) unf_d = 1'b1;
                    else       stk_d[0] = -stk_q[0];
                end
                3'b111: begin
                    stk_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            stk_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            stk_q   <= stk_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.top     = stk_q[0];
    assign bus.second  = stk_q[1];
    assign bus.depth   = cnt_q;
    assign bus.carry   = carry_q;
    assign bus.err_ovf = ovf_q;
    assign bus.err_unf = unf_q;
endmodule

// File: tb/tb_rpn_stack_core.sv
// tb_rpn_stack_core: vector table, key-timing sequences and a random run
// checked against a queue-based model of the calculator stack.
module tb_rpn_stack_core;
    localparam int W   = 8;
    localparam int D   = 4;
    localparam int MOD = 1 << W;

    logic       clk = 1'b0;
    logic [3:0] key = 4'hF;

    always #5 clk = ~clk;

    rpn_stack_core_if #(.WIDTH(W), .DEPTH(D)) bus();

    rpn_stack_core #(.WIDTH(W), .DEPTH(D)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    int unsigned mq[$];
    int          m_carry, m_ovf, m_unf;

    typedef struct {
        int p, d, op, t, s, dep, c, o, u;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input int p, d, op, t, s, dep, c, o, u);
        vec_t r;
        r.p = p; r.d = d; r.op = op; r.t = t; r.s = s;
        r.dep = dep; r.c = c; r.o = o; r.u = u;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string n, input int t, s, dep, c, o, u);
        chk({n, ".top"},     int'(bus.top),     t);
        chk({n, ".second"},  int'(bus.second),  s);
        chk({n, ".depth"},   int'(bus.depth),   dep);
        chk({n, ".carry"},   int'(bus.carry),   c);
        chk({n, ".err_ovf"}, int'(bus.err_ovf), o);
        chk({n, ".err_unf"}, int'(bus.err_unf), u);
    endtask

    function automatic void m_reset();
        mq.delete();
        m_carry = 0; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic void m_push(input int unsigned d);
        if (mq.size() == D) m_ovf = 1;
        else mq.push_front(d);
    endfunction

    function automatic void m_exec(input int op);
        int unsigned a, b, r;
        case (op)
            0, 1, 2: begin
`ifndef RPN_MUL_EN
                if (op == 2) return;
`endif
                if (mq.size() < 2) begin m_unf = 1; return; end
                b = mq.pop_front();
                a = mq.pop_front();
                if (op == 0) r = a + b;
                else if (op == 1) r = a + MOD - b;
                else r = a * b;
                if (op == 1) m_carry = (a < b) ? 1 : 0;
                else m_carry = (r >= MOD) ? 1 : 0;
                mq.push_front(r % MOD);
            end
            3: begin
                if (mq.size() < 2) begin m_unf = 1; return; end
                a = mq[0]; mq[0] = mq[1]; mq[1] = a;
            end
            4: begin
                if (mq.size() < 1) m_unf = 1;
                else if (mq.size() == D) m_ovf = 1;
                else mq.push_front(mq[0]);
            end
            5: begin
                if (mq.size() < 1) m_unf = 1;
                else void'(mq.pop_front());
            end
            6: begin
                if (mq.size() < 1) m_unf = 1;
                else mq[0] = (MOD - mq[0]) % MOD;
            end
            default: m_reset();
        endcase
    endfunction

    task automatic chk_model(input string n);
        chk_out(n,
                mq.size() > 0 ? int'(mq[0]) : 0,
                mq.size() > 1 ? int'(mq[1]) : 0,
                mq.size(), m_carry, m_ovf, m_unf);
        chk({n, ".busy"}, int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        key = 4'b1101;
        repeat (3) @(negedge clk);
        key = 4'hF;
        m_reset();
        repeat (2) @(negedge clk);
    endtask

    // one-cycle press; returns 1ns after the commit edge k+3
    task automatic press_at(input bit p, input bit e);
        @(negedge clk);
        key[0] = ~p;
        key[2] = ~e;
        @(posedge clk);
        #1;
        key[0] = 1'b1;
        key[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit p, input bit e);
        int n;
        press_at(p, e);
        n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy) chk("busy_timeout", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input int d);
        bus.data_in = W'(d);
        press(1'b1, 1'b0);
    endtask

    task automatic exec(input int op);
        bus.op = 3'(op);
        press(1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.data_in = '0;
        bus.op      = '0;

        tbl.push_back(v(1, 'hAE, 0, 'hAE, 'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 'h83, 0, 'h83, 'hAE, 2, 0, 0, 0));
        tbl.push_back(v(0, 0,    0, 'h31, 'h00, 1, 1, 0, 0));
        tbl.push_back(v(0, 0,    7, 'h00, 'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 'hAE, 0, 'hAE, 'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 'h83, 0, 'h83, 'hAE, 2, 0, 0, 0));
        tbl.push_back(v(0, 0,    1, 'h2B, 'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 'hFF, 0, 'hFF, 'h2B, 2, 0, 0, 0));
        tbl.push_back(v(0, 0,    1, 'h2C, 'h00, 1, 1, 0, 0));
        tbl.push_back(v(0, 0,    6, 'hD4, 'h00, 1, 1, 0, 0));
        tbl.push_back(v(0, 0,    4, 'hD4, 'hD4, 2, 1, 0, 0));
        tbl.push_back(v(1, 'h01, 0, 'h01, 'hD4, 3, 1, 0, 0));
        tbl.push_back(v(0, 0,    3, 'hD4, 'h01, 3, 1, 0, 0));
        tbl.push_back(v(0, 0,    5, 'h01, 'hD4, 2, 1, 0, 0));
        tbl.push_back(v(0, 0,    0, 'hD5, 'h00, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,    0, 'hD5, 'h00, 1, 0, 0, 1));
        tbl.push_back(v(0, 0,    5, 'h00, 'h00, 0, 0, 0, 1));
        tbl.push_back(v(0, 0,    4, 'h00, 'h00, 0, 0, 0, 1));
        tbl.push_back(v(0, 0,    6, 'h00, 'h00, 0, 0, 0, 1));
        tbl.push_back(v(0, 0,    7, 'h00, 'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 'h01, 0, 'h01, 'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 'h02, 0, 'h02, 'h01, 2, 0, 0, 0));
        tbl.push_back(v(1, 'h03, 0, 'h03, 'h02, 3, 0, 0, 0));
        tbl.push_back(v(1, 'h04, 0, 'h04, 'h03, 4, 0, 0, 0));
        tbl.push_back(v(0, 0,    4, 'h04, 'h03, 4, 0, 1, 0));
        tbl.push_back(v(0, 0,    7, 'h00, 'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 'h83, 0, 'h83, 'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 'h83, 0, 'h83, 'h83, 2, 0, 0, 0));
        tbl.push_back(v(1, 'h83, 0, 'h83, 'h83, 3, 0, 0, 0));
        tbl.push_back(v(1, 'h83, 0, 'h83, 'h83, 4, 0, 0, 0));
        tbl.push_back(v(1, 'h83, 0, 'h83, 'h83, 4, 0, 1, 0));
        tbl.push_back(v(0, 0,    7, 'h00, 'h00, 0, 0, 0, 0));

        do_reset();
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.busy", int'(bus.busy), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].p != 0) push(tbl[i].d);
            else exec(tbl[i].op);
            chk_out($sformatf("vec%0d", i), tbl[i].t, tbl[i].s,
                    tbl[i].dep, tbl[i].c, tbl[i].o, tbl[i].u);
        end

        // press latency: sampled at edge k, committed at edge k+3
        do_reset();
        @(negedge clk);
        bus.data_in = 8'h3C;
        key[0] = 1'b0;
        @(posedge clk);
        #1;
        key[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("lat_k2.depth", int'(bus.depth), 0);
        @(posedge clk);
        #1;
        chk("lat_k3.depth", int'(bus.depth), 1);
        chk("lat_k3.top", int'(bus.top), 'h3C);

        // holding the key gives a single push
        do_reset();
        bus.data_in = 8'h05;
        @(negedge clk);
        key[0] = 1'b0;
        repeat (20) @(negedge clk);
        key[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk_out("hold", 'h05, 0, 1, 0, 0, 0);

        // push and DROP in the same cycle: push wins
        bus.data_in = 8'h22;
        bus.op = 3'd5;
        press(1'b1, 1'b1);
        chk_out("push_drop", 'h22, 'h05, 2, 0, 0, 0);

`ifdef RPN_MUL_EN
        do_reset();
        push('h0C);
        push('h0B);
        bus.op = 3'd2;
        bus.data_in = 8'h77;
        press_at(1'b0, 1'b1);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (n == 1) key[0] = 1'b0;
            if (n == 2) key[0] = 1'b1;
            if (n == 3) key[2] = 1'b0;
            if (n == 4) key[2] = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("mul.busy_cycles", n, 8);
        chk_out("mul", 'h84, 0, 1, 0, 0, 0);
        repeat (6) @(negedge clk);
        chk_out("mul_ignored", 'h84, 0, 1, 0, 0, 0);
        chk("mul_ignored.busy", int'(bus.busy), 0);

        do_reset();
        bus.op = 3'd2;
        press_at(1'b0, 1'b1);
        chk("mul_unf.busy", int'(bus.busy), 0);
        chk("mul_unf.err_unf", int'(bus.err_unf), 1);

        do_reset();
        push('hFF);
        push('hFF);
        bus.op = 3'd2;
        press_at(1'b0, 1'b1);
        chk("mul_abort.busy_rise", int'(bus.busy), 1);
        repeat (2) @(posedge clk);
        #1;
        key[1] = 1'b0;
        #1;
        chk_out("mul_abort", 0, 0, 0, 0, 0, 0);
        chk("mul_abort.busy", int'(bus.busy), 0);
        @(negedge clk);
        key[1] = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        push('h05);
        chk_out("after_abort", 'h05, 0, 1, 0, 0, 0);
`else
        do_reset();
        push('h0C);
        push('h0B);
        exec(2);
        chk_out("mul_noop", 'h0B, 'h0C, 2, 0, 0, 0);
        chk("mul_noop.busy", int'(bus.busy), 0);
        do_reset();
        exec(2);
        chk_out("mul_noop_empty", 0, 0, 0, 0, 0, 0);
`endif

        do_reset();
        for (int i = 0; i < 160; i++) begin
            int op;
            int unsigned d;
            op = int'($urandom_range(0, 7));
            d  = $urandom_range(0, MOD - 1);
            if ($urandom_range(0, 1) == 0 || (op == 7 && $urandom_range(0, 3) != 0)) begin
                push(int'(d));
                m_push(d);
            end else begin
                exec(op);
                m_exec(op);
            end
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
